// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: TAP state encoding, instruction opcodes,
// the Capture-IR pattern and the data-register select type.
package jtag_pkg;

    // 4-bit TAP state encoding; the value is exported on TAP_STATE for debug.
    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    // Instruction opcodes; anything not listed behaves as BYPASS.
    localparam logic [3:0] OPC_EXTEST   = 4'h0;
    localparam logic [3:0] OPC_SAMPLE   = 4'h1;
    localparam logic [3:0] OPC_IDCODE   = 4'h2;
    localparam logic [3:0] OPC_CORE_DBG = 4'h8;
    localparam logic [3:0] OPC_BYPASS   = 4'hF;

    // Low two bits loaded into the IR shift register in Capture-IR; upper bits are 0.
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

    // Which data register feeds TDO while in Shift-DR.
    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_BSR    = 2'd2,
        DR_CORE   = 2'd3
    } dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register plus TMS-driven next-state logic.
// The next state is exported so the IR can be reset on the edge that enters
// Test-Logic-Reset rather than one cycle later.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       rst_n,
    input  logic       tms,
    output tap_state_e state,
    output tap_state_e state_next
);

    tap_state_e state_q;
    tap_state_e state_d;

    // Standard TAP transition table selected by TMS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    // State register; TRST*-style reset forces Test-Logic-Reset at any time.
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign state      = state_q;
    assign state_next = state_d;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller top: TAP FSM, instruction register, bypass and IDCODE
// registers, DR strobes for core_logic / boundary scan, and the TDO mux.
// Build option: define JTAG_IDCODE_EN to include the IDCODE instruction and
// register and make IDCODE the reset instruction; otherwise the IDCODE opcode
// decodes as BYPASS and BYPASS is the reset instruction.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0DDD
) (
    input  logic       TCK,
    input  logic       rst_n,
    input  logic       TMS,
    input  logic       TDI,
    output logic       TDO,
    output logic       TDO_OE,
    input  logic       CORE_LOGIC_TDO,
    input  logic       BSR_TDO,
    output logic       SHIFTDR,
    output logic       CAPTUREDR,
    output logic       UPDATEDR,
    output logic       SELECT_BSR,
    output logic       SELECT_CORE,
    output logic       EXTEST_MODE,
    output logic [3:0] TAP_STATE
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_LSBS);
    localparam logic [IR_WIDTH-1:0] IR_BYPASS  = {IR_WIDTH{1'b1}};
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_WIDTH'(OPC_IDCODE);
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_BYPASS;
`endif

    // An IDCODE with bit0 clear would be indistinguishable from a bypass bit.
    if (IDCODE_VALUE[0] != 1'b1) begin : g_idcode_lsb_check
        $error("IDCODE_VALUE bit0 must be 1");
    end

    tap_state_e tap_state;
    tap_state_e tap_state_next;

    jtag_tap_fsm u_fsm (
        .tck        (TCK),
        .rst_n      (rst_n),
        .tms        (TMS),
        .state      (tap_state),
        .state_next (tap_state_next)
    );

    logic [IR_WIDTH-1:0] ir_q, ir_d;        // active instruction
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;  // instruction shift register
    logic                bypass_q, bypass_d;
`ifdef JTAG_IDCODE_EN
    logic [31:0]         idsreg_q, idsreg_d;
`endif
    logic                tdo_q, tdo_d;
    logic                tdo_oe_q, tdo_oe_d;

    logic    is_extest;
    logic    is_sample;
    logic    is_core;
    dr_sel_e dr_sel;

    // Instruction decode; unknown opcodes fall through to BYPASS.
    always_comb begin
        is_extest = (ir_q == IR_WIDTH'(OPC_EXTEST));
        is_sample = (ir_q == IR_WIDTH'(OPC_SAMPLE));
        is_core   = (ir_q == IR_WIDTH'(OPC_CORE_DBG));
        dr_sel    = DR_BYPASS;
        if (is_extest || is_sample) begin
            dr_sel = DR_BSR;
        end else if (is_core) begin
            dr_sel = DR_CORE;
        end
`ifdef JTAG_IDCODE_EN
        else if (ir_q == IR_WIDTH'(OPC_IDCODE)) begin
            dr_sel = DR_IDCODE;
        end
`endif
    end

    // IR path: capture/shift the shift register; the active IR only changes in
    // Update-IR or when the TAP is about to sit in Test-Logic-Reset.
    always_comb begin
        ir_sr_d = ir_sr_q;
        ir_d    = ir_q;
        if (tap_state == CAPTURE_IR) begin
            ir_sr_d = IR_CAPTURE;
        end else if (tap_state == SHIFT_IR) begin
            ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
        end
        if (tap_state_next == TEST_LOGIC_RESET) begin
            ir_d = IR_RESET;
        end else if (tap_state == UPDATE_IR) begin
            ir_d = ir_sr_q;
        end
    end

    // Internal DRs: bypass captures 0, IDCODE captures the device ID; both shift TDI in.
    always_comb begin
        bypass_d = bypass_q;
        if (tap_state == CAPTURE_DR) begin
            bypass_d = 1'b0;
        end else if (tap_state == SHIFT_DR) begin
            bypass_d = TDI;
        end
`ifdef JTAG_IDCODE_EN
        idsreg_d = idsreg_q;
        if (tap_state == CAPTURE_DR) begin
            idsreg_d = IDCODE_VALUE;
        end else if (tap_state == SHIFT_DR) begin
            idsreg_d = {TDI, idsreg_q[31:1]};
        end
`endif
    end

    // TDO source selection; outside the shift states TDO holds and is disabled.
    always_comb begin
        tdo_d    = tdo_q;
        tdo_oe_d = 1'b0;
        if (tap_state == SHIFT_IR) begin
            tdo_d    = ir_sr_q[0];
            tdo_oe_d = 1'b1;
        end else if (tap_state == SHIFT_DR) begin
            tdo_oe_d = 1'b1;
            case (dr_sel)
`ifdef JTAG_IDCODE_EN
                DR_IDCODE: tdo_d = idsreg_q[0];
`endif
                DR_BSR:    tdo_d = BSR_TDO;
                DR_CORE:   tdo_d = CORE_LOGIC_TDO;
                default:   tdo_d = bypass_q;
            endcase
        end
    end

    // Rising-edge registers: IR and internal data registers.
    always_ff @(posedge TCK or negedge rst_n) begin
        if (!rst_n) begin
            ir_q     <= IR_RESET;
            ir_sr_q  <= IR_CAPTURE;
            bypass_q <= 1'b0;
`ifdef JTAG_IDCODE_EN
            idsreg_q <= IDCODE_VALUE;
`endif
        end else begin
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            bypass_q <= bypass_d;
`ifdef JTAG_IDCODE_EN
            idsreg_q <= idsreg_d;
`endif
        end
    end

    // Falling-edge TDO register so the pin is stable around the next rising edge.
    always_ff @(negedge TCK or negedge rst_n) begin
        if (!rst_n) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

    assign TDO         = tdo_q;
    assign TDO_OE      = tdo_oe_q;
    assign SHIFTDR     = (tap_state == SHIFT_DR) && ((dr_sel == DR_BSR) || (dr_sel == DR_CORE));
    assign CAPTUREDR   = (tap_state == CAPTURE_DR);
    assign UPDATEDR    = (tap_state == UPDATE_DR);
    assign SELECT_BSR  = is_extest || is_sample;
    assign SELECT_CORE = is_core;
    assign EXTEST_MODE = is_extest;
    assign TAP_STATE   = tap_state;

endmodule
